uart_frame_decoder: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_gap_timer.sv | 31 +++
 rtl/uart_frame_decoder.sv | 123 ++++++++++++
 tb/tb_uart_frame_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART frame decoder
package uart_pkg;

  localparam int         DEF_DATA_WIDTH = 8;
  localparam logic [7:0] DEF_SOF_BYTE   = 8'hA5;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    CHK     = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - inter-byte gap counter, pulses expire after TIMEOUT_CYC idle cycles
module uart_gap_timer
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  assign expire = run && !clear && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || clear || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - parses SOF/LEN/payload/CHK frames from the RX FIFO
// and streams the payload over valid/ready with a per-packet verdict pulse.
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                    MAX_LEN     = 64,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE    = DATA_WIDTH'(DEF_SOF_BYTE),
  parameter int                    TIMEOUT_CYC = 100000
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] R_data,
  input  logic                  rx_empty,
  output logic                  rd_uart,
  output logic [DATA_WIDTH-1:0] pl_data,
  output logic                  pl_valid,
  input  logic                  pl_ready,
  output logic                  pl_last,
  output logic                  pkt_ok,
  output logic                  pkt_err,
  output logic [1:0]            err_code
);

  localparam logic [DATA_WIDTH-1:0] MAX_LEN_W = DATA_WIDTH'(MAX_LEN);
  localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] cnt, sum;
  logic                  len_bad, expire;

  assign len_bad = (R_data == '0) || (R_data > MAX_LEN_W);

  // Any visible FIFO byte restarts the gap count, so a stalled client never times out.
  uart_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap (
    .clk    (UCLK),
    .rst    (reset),
    .run    (state != HUNT),
    .clear  (!rx_empty),
    .expire (expire)
  );

  always_ff @(posedge UCLK or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      HUNT:    if (rd_uart && R_data == SOF_BYTE) state_nx = LEN;
      LEN:     if (rd_uart)                       state_nx = len_bad ? HUNT : PAYLOAD;
               else if (expire)                   state_nx = HUNT;
      PAYLOAD: if (rd_uart && cnt == ONE)         state_nx = CHK;
               else if (expire)                   state_nx = HUNT;
      CHK:     if (rd_uart || expire)             state_nx = HUNT;
      default:                                    state_nx = HUNT;
    endcase
  end

  always_comb begin
    rd_uart = 1'b0;
    if (!reset) begin
      case (state)
        PAYLOAD: rd_uart = !rx_empty && (!pl_valid || pl_ready);
        default: rd_uart = !rx_empty;
      endcase
    end
  end

  always_ff @(posedge UCLK or posedge reset) begin
    if (reset) begin
      pl_data  <= '0;
      pl_valid <= 1'b0;
      pl_last  <= 1'b0;
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= ERR_NONE;
      cnt      <= '0;
      sum      <= '0;
    end else begin
      pkt_ok   <= 1'b0;
      pkt_err  <= 1'b0;
      err_code <= ERR_NONE;
      if (pl_valid && pl_ready) begin
        pl_valid <= 1'b0;
        pl_last  <= 1'b0;
      end
      case (state)
        LEN: if (rd_uart) begin
          sum <= R_data;
          cnt <= R_data;
          if (len_bad) begin
            pkt_err  <= 1'b1;
            err_code <= ERR_LEN;
          end
        end
        PAYLOAD: if (rd_uart) begin
          pl_data  <= R_data;
          pl_valid <= 1'b1;
          pl_last  <= (cnt == ONE);
          sum      <= sum + R_data;
          cnt      <= cnt - ONE;
        end
        CHK: if (rd_uart) begin
          if (R_data == sum) begin
            pkt_ok <= 1'b1;
          end else begin
            pkt_err  <= 1'b1;
            err_code <= ERR_CHK;
          end
        end
        default: ;
      endcase
      // Expiry only happens with the FIFO empty, so it never coincides with a pop.
      if (expire) begin
        pkt_err  <= 1'b1;
        err_code <= ERR_TMO;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - scoreboard bench for uart_frame_decoder with a frame-level reference parser
module tb_uart_frame_decoder;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] R_data;
  logic       rx_empty;
  logic       rd_uart;
  logic [7:0] pl_data;
  logic       pl_valid, pl_ready, pl_last, pkt_ok, pkt_err;
  logic [1:0] err_code;

  uart_frame_decoder #(
    .DATA_WIDTH(8), .MAX_LEN(64), .SOF_BYTE(8'hA5), .TIMEOUT_CYC(TMO)
  ) dut (
    .UCLK(clk), .reset(rst), .R_data(R_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_last(pl_last),
    .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo[$];
  logic [8:0] exp_pl[$];
  logic [1:0] exp_v[$];
  int n_pass  = 0;
  int n_total = 0;
  int ready_mode = 0;
  bit gap_en = 1'b0;
  int stall_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got %0h expected none at %0t", name, act, $time);
  endtask

  // Frame-level reference: walk the byte stream; a stream ending inside a frame means timeout.
  task automatic model(input logic [7:0] b[$]);
    int i, len, s;
    i = 0;
    while (i < b.size()) begin
      if (b[i] != 8'hA5) begin
        i++;
      end else begin
        i++;
        if (i >= b.size()) begin exp_v.push_back(2'b11); return; end
        len = int'(b[i]);
        i++;
        if (len == 0 || len > 64) begin
          exp_v.push_back(2'b01);
        end else begin
          s = len;
          for (int k = 0; k < len; k++) begin
            if (i >= b.size()) begin exp_v.push_back(2'b11); return; end
            exp_pl.push_back({(k == len - 1), b[i]});
            s = (s + int'(b[i])) % 256;
            i++;
          end
          if (i >= b.size()) begin exp_v.push_back(2'b11); return; end
          exp_v.push_back((int'(b[i]) == s) ? 2'b00 : 2'b10);
          i++;
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b[$]);
    model(b);
    foreach (b[j]) fifo.push_back(b[j]);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo.size() != 0 || exp_pl.size() != 0 || exp_v.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (fifo.size() != 0 || exp_pl.size() != 0 || exp_v.size() != 0) begin
      fail_now("drain_timeout", fifo.size() + exp_pl.size() + exp_v.size());
      fifo.delete();
      exp_pl.delete();
      exp_v.delete();
    end
    repeat (TMO + 6) @(negedge clk);
  endtask

  initial begin : driver
    int  run_hidden;
    bit  hide, stalled, pop_now;
    run_hidden = 0;
    R_data = 8'h00;
    rx_empty = 1'b1;
    pl_ready = 1'b1;
    forever begin
      @(negedge clk);
      hide = gap_en && run_hidden < 2 && $urandom_range(0, 3) == 0;
      run_hidden = hide ? run_hidden + 1 : 0;
      rx_empty = hide || fifo.size() == 0;
      R_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
      stalled = 1'b0;
      if (stall_left > 0 && pl_valid && pl_data == 8'h22) begin
        pl_ready = 1'b0;
        stall_left--;
        stalled = 1'b1;
      end else begin
        case (ready_mode)
          0:       pl_ready = 1'b1;
          1:       pl_ready = 1'($urandom_range(0, 1));
          default: pl_ready = 1'b0;
        endcase
      end
      #1;
      if (stalled) check("stall_rd_uart", rd_uart, 0);
      pop_now = rd_uart;
      @(posedge clk);
      if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
    end
  end

  initial begin : monitor
    logic [1:0] got;
    logic [8:0] prev_pl;
    bit         prev_stall;
    prev_stall = 1'b0;
    prev_pl = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("hold_stable", {pl_valid, pl_last, pl_data}, {1'b1, prev_pl});
        if (pl_valid && pl_ready) begin
          if (exp_pl.size() == 0) fail_now("payload_unexpected", {pl_last, pl_data});
          else check("payload", {pl_last, pl_data}, exp_pl.pop_front());
        end
        prev_stall = pl_valid && !pl_ready;
        prev_pl = {pl_last, pl_data};
        if (pkt_ok || pkt_err) begin
          check("pulse_exclusive", {pkt_ok, pkt_err} == 2'b11, 0);
          got = pkt_ok ? 2'b00 : err_code;
          if (exp_v.size() == 0) fail_now("verdict_unexpected", got);
          else check("verdict", got, exp_v.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] bq[$];
    int kind, len, s, n;
    logic [7:0] b;

    rst = 1'b1;
    fifo.push_back(8'hA5);
    repeat (3) @(negedge clk);
    #2;
    check("rst_rd_uart", rd_uart, 0);
    check("rst_pl_valid", pl_valid, 0);
    check("rst_pl_data", pl_data, 0);
    check("rst_pl_last", pl_last, 0);
    check("rst_pkt_ok", pkt_ok, 0);
    check("rst_pkt_err", pkt_err, 0);
    check("rst_err_code", err_code, 0);
    fifo.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;

    bq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send(bq); drain(200);

    bq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send(bq); drain(200);

    bq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send(bq); drain(200);

    bq = '{8'hA5, 8'h00, 8'hA5, 8'h41, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send(bq); drain(200);

    // Largest legal length, payload includes the SOF value as plain data.
    bq = '{8'hA5, 8'h40};
    s = 64;
    for (int k = 0; k < 64; k++) begin
      b = (k % 7 == 0) ? 8'hA5 : 8'(k * 3);
      bq.push_back(b);
      s = (s + int'(b)) % 256;
    end
    bq.push_back(8'(s));
    send(bq); drain(400);

    stall_left = 5;
    bq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send(bq); drain(200);
    check("stall_cycles_used", stall_left, 0);

    bq = '{8'hA5, 8'h03, 8'h11};
    send(bq); drain(200);
    bq = '{8'hA5};
    send(bq); drain(200);
    bq = '{8'hA5, 8'h01, 8'h7E};
    send(bq); drain(200);

    // Reset while a payload byte is held by a stalled client.
    ready_mode = 2;
    bq = '{8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h14};
    foreach (bq[j]) fifo.push_back(bq[j]);
    n = 0;
    while (!pl_valid && n < 50) begin @(negedge clk); n++; end
    check("reached_payload", pl_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rd_uart", rd_uart, 0);
    check("midrst_pl_valid", pl_valid, 0);
    check("midrst_pl_data", pl_data, 0);
    check("midrst_pl_last", pl_last, 0);
    check("midrst_pulses", {pkt_ok, pkt_err, err_code}, 0);
    fifo.delete();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    ready_mode = 0;
    bq = '{8'hA5, 8'h02, 8'hA5, 8'h10, 8'hB7};
    send(bq); drain(200);

    ready_mode = 1;
    gap_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      bq.delete();
      repeat ($urandom_range(1, 3)) begin
        kind = $urandom_range(0, 5);
        if (kind == 5) begin
          repeat ($urandom_range(1, 3)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            bq.push_back(b);
          end
        end else if (kind == 4) begin
          bq.push_back(8'hA5);
          bq.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(65, 255)));
        end else begin
          len = (kind == 0) ? (($urandom_range(0, 1) == 0) ? 1 : 64) : $urandom_range(1, 64);
          bq.push_back(8'hA5);
          bq.push_back(8'(len));
          s = len;
          for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            bq.push_back(b);
            s = (s + int'(b)) % 256;
          end
          if (kind == 3) s = (s + $urandom_range(1, 255)) % 256;
          bq.push_back(8'(s));
        end
      end
      send(bq);
      drain(3000);
    end

    check("left_payload", exp_pl.size(), 0);
    check("left_verdicts", exp_v.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
